// File: rtl/packet_buffer_arbiter_if.sv
// Packet buffer arbiter bus: two read requesters, two write requesters and
// the RAM-driver side, grouped into one bundle.
// slave  = the arbiter, master = requesters plus RAM driver.
interface packet_buffer_arbiter_if #(
    parameter int AW       = 11,
    parameter int WORD_LEN = 8
);
    logic                rd0_req, rd1_req;
    logic [AW-1:0]       rd0_addr, rd1_addr;
    logic                rd0_gnt, rd1_gnt;
    logic                rd0_ready, rd1_ready;
    logic [WORD_LEN-1:0] rd0_out, rd1_out;

    logic                wr0_en, wr1_en;
    logic [AW-1:0]       wr0_addr, wr1_addr;
    logic [WORD_LEN-1:0] wr0_val, wr1_val;
    logic                wr0_gnt, wr1_gnt;

    logic                ram_read_req;
    logic [AW-1:0]       ram_read_addr;
    logic                ram_read_ready;
    logic [WORD_LEN-1:0] ram_read_out;
    logic                ram_write_enable;
    logic [AW-1:0]       ram_write_addr;
    logic [WORD_LEN-1:0] ram_write_val;

    logic                err;

    modport slave (
        input  rd0_req, rd1_req, rd0_addr, rd1_addr,
        output rd0_gnt, rd1_gnt, rd0_ready, rd1_ready, rd0_out, rd1_out,
        input  wr0_en, wr1_en, wr0_addr, wr1_addr, wr0_val, wr1_val,
        output wr0_gnt, wr1_gnt,
        output ram_read_req, ram_read_addr,
        input  ram_read_ready, ram_read_out,
        output ram_write_enable, ram_write_addr, ram_write_val,
        output err
    );

    modport master (
        output rd0_req, rd1_req, rd0_addr, rd1_addr,
        input  rd0_gnt, rd1_gnt, rd0_ready, rd1_ready, rd0_out, rd1_out,
        output wr0_en, wr1_en, wr0_addr, wr1_addr, wr0_val, wr1_val,
        input  wr0_gnt, wr1_gnt,
        input  ram_read_req, ram_read_addr,
        output ram_read_ready, ram_read_out,
        input  ram_write_enable, ram_write_addr, ram_write_val,
        input  err
    );
endinterface

// File: rtl/packet_buffer_arbiter.sv
// Packet buffer arbiter: shares one RAM driver between two readers and two
// writers. Read grants are combinational; a READ_LATENCY-deep tag pipeline
// routes each returning word to the requester that issued it.
// Optional macro PKTBUF_ARB_RR_EN: round-robin read arbitration
// (default build: fixed priority rd0 > rd1, no pointer state).
`ifndef PACKET_BUFFER_SIZE
`define PACKET_BUFFER_SIZE 2048
`endif
`ifndef BYTE_LEN
`define BYTE_LEN 8
`endif

module packet_buffer_arbiter #(
    parameter int RAM_SIZE     = `PACKET_BUFFER_SIZE,
    parameter int WORD_LEN     = `BYTE_LEN,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    packet_buffer_arbiter_if.slave bus
);
    localparam int AW = $clog2(RAM_SIZE);

    logic                    rd0_gnt, rd1_gnt, rd_pick1;
    logic                    wr0_gnt, wr1_gnt;
    logic [AW-1:0]           rd_addr_sel;
    logic [WORD_LEN-1:0]     wr_val_sel;
    logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [READ_LATENCY-1:0] tag_id_q, tag_id_d;
    logic                    tail_vld, tail_id;
    logic                    err_q, err_d;

`ifdef PKTBUF_ARB_RR_EN
    logic rr_next_q, rr_next_d;   // requester that wins the next contention

    // Pointer moves to the requester that was not just granted
    always_comb begin
        rr_next_d = rr_next_q;
        if (rd0_gnt)      rr_next_d = 1'b1;
        else if (rd1_gnt) rr_next_d = 1'b0;
    end

    // Round-robin pointer register, requester 0 first after reset
    always_ff @(posedge clk) begin
        if (!rstn) rr_next_q <= 1'b0;
        else       rr_next_q <= rr_next_d;
    end

    assign rd_pick1 = bus.rd1_req & (~bus.rd0_req | rr_next_q);
`else
    assign rd_pick1 = bus.rd1_req & ~bus.rd0_req;
`endif

    // Read/write arbitration and RAM request muxing; nothing granted in reset
    always_comb begin
        rd0_gnt     = rstn & bus.rd0_req & ~rd_pick1;
        rd1_gnt     = rstn & rd_pick1;
        rd_addr_sel = rd1_gnt ? bus.rd1_addr : bus.rd0_addr;
        wr0_gnt     = rstn & bus.wr0_en;
        wr1_gnt     = rstn & bus.wr1_en & ~bus.wr0_en;
        wr_val_sel  = wr1_gnt ? bus.wr1_val : bus.wr0_val;
    end

    // Tag pipeline shifts every cycle; the head records this cycle's grant
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = rd0_gnt | rd1_gnt;
        tag_id_d[0]  = rd1_gnt;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    assign tail_vld = tag_vld_q[READ_LATENCY-1];
    assign tail_id  = tag_id_q[READ_LATENCY-1];

    // Data returning with no read in flight is a protocol error; sticky
    always_comb begin
        err_d = err_q | (bus.ram_read_ready & ~tail_vld);
    end

    // Tag and error registers; reset discards reads already in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            err_q     <= err_d;
        end
    end

    assign bus.rd0_gnt          = rd0_gnt;
    assign bus.rd1_gnt          = rd1_gnt;
    assign bus.ram_read_req     = rd0_gnt | rd1_gnt;
    assign bus.ram_read_addr    = rd_addr_sel;
    assign bus.rd0_ready        = rstn & bus.ram_read_ready & tail_vld & ~tail_id;
    assign bus.rd1_ready        = rstn & bus.ram_read_ready & tail_vld & tail_id;
    assign bus.rd0_out          = bus.ram_read_out;
    assign bus.rd1_out          = bus.ram_read_out;
    assign bus.wr0_gnt          = wr0_gnt;
    assign bus.wr1_gnt          = wr1_gnt;
    assign bus.ram_write_enable = wr0_gnt | wr1_gnt;
    assign bus.ram_write_addr   = wr1_gnt ? bus.wr1_addr : bus.wr0_addr;
    assign bus.ram_write_val    = wr_val_sel;
    assign bus.err              = err_q & rstn;
endmodule
